count_cascade: RTL and testbench



---
 rtl/count_cascade_pkg.sv | 9 +
 rtl/count_mod_n.sv | 54 +++++
 rtl/count_cascade.sv | 60 ++++++
 tb/tb_count_cascade.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/count_cascade_pkg.sv
// Shared types for the cascaded modulo counter.
package count_cascade_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/count_mod_n.sv
// One modulo-MOD up/down stage with clamped parallel load, registered
// terminal flag and combinational wrap used to step the next stage.
module count_mod_n
    import count_cascade_pkg::*;
#(
    parameter int unsigned MOD = 10,
    parameter int unsigned W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         ld,
    input  logic [W-1:0] din,
    output logic [W-1:0] count,
    output logic         tc,
    output logic         wrap
);

    localparam logic [W-1:0] MAX = W'(MOD - 1);

    logic         dir_up;
    logic         at_term;
    logic [W-1:0] count_nxt;
    logic         tc_nxt;

    assign dir_up  = (dir_e'(up) == DIR_UP);
    assign at_term = dir_up ? (count == MAX) : (count == '0);
    assign wrap    = en & at_term;

    // Next count: load (clamped to MAX) beats counting.
    always_comb begin
        count_nxt = count;
        if (ld) begin
            count_nxt = ({1'b0, din} >= (W+1)'(MOD)) ? MAX : din;
        end else if (en) begin
            if (dir_up) count_nxt = at_term ? '0 : count + W'(1);
            else        count_nxt = at_term ? MAX : count - W'(1);
        end
        tc_nxt = dir_up ? (count_nxt == MAX) : (count_nxt == '0);
    end

    // Flag only refreshes on edges that update the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (ld || en) begin
            count <= count_nxt;
            tc    <= tc_nxt;
        end
    end

endmodule

// File: rtl/count_cascade.sv
// Two-stage cascaded modulo counter (LO_MOD x HI_MOD) with up/down,
// parallel load, chain terminal flag and cascade carry/borrow out.
module count_cascade
    import count_cascade_pkg::*;
#(
    parameter int unsigned LO_MOD = 10,
    parameter int unsigned HI_MOD = 6,
    parameter int unsigned LO_W   = 4,
    parameter int unsigned HI_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            up,
    input  logic            ld,
    input  logic [LO_W-1:0] ld_lo,
    input  logic [HI_W-1:0] ld_hi,
    output logic [LO_W-1:0] count_lo,
    output logic [HI_W-1:0] count_hi,
    output logic            tc_lo,
    output logic            co,
    output logic            cy
);

    logic lo_wrap;
    logic hi_en;
    logic hi_wrap;
    logic tc_hi;

    assign hi_en = en & lo_wrap;

    count_mod_n #(.MOD(LO_MOD), .W(LO_W)) u_lo (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .up    (up),
        .ld    (ld),
        .din   (ld_lo),
        .count (count_lo),
        .tc    (tc_lo),
        .wrap  (lo_wrap)
    );

    count_mod_n #(.MOD(HI_MOD), .W(HI_W)) u_hi (
        .clk   (clk),
        .rst   (rst),
        .en    (hi_en),
        .up    (up),
        .ld    (ld),
        .din   (ld_hi),
        .count (count_hi),
        .tc    (tc_hi),
        .wrap  (hi_wrap)
    );

    // hi_wrap already includes the low-stage wrap through hi_en.
    assign cy = hi_wrap;
    assign co = tc_lo & tc_hi;

endmodule

// File: tb/tb_count_cascade.sv
// Scoreboard bench for count_cascade: default 10x6 instance plus a 6x2 instance.
module tb_count_cascade;

    typedef struct {
        logic [3:0] lo;
        logic [3:0] hi;
        logic       tclo;
        logic       co;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en, up, ld;
    logic [3:0] ld_lo, ld_hi;
    logic [3:0] count_lo, count_hi;
    logic       tc_lo, co, cy;

    logic [2:0] ld_lo2 = 3'd0;
    logic [0:0] ld_hi2 = 1'b0;
    logic [2:0] count_lo2;
    logic [0:0] count_hi2;
    logic       tc_lo2, co2, cy2;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    int   m_lo, m_hi;
    bit   m_tclo, m_tchi;

    always #5 clk = ~clk;

    count_cascade dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .ld(ld),
        .ld_lo(ld_lo), .ld_hi(ld_hi),
        .count_lo(count_lo), .count_hi(count_hi),
        .tc_lo(tc_lo), .co(co), .cy(cy)
    );

    count_cascade #(.LO_MOD(6), .HI_MOD(2), .LO_W(3), .HI_W(1)) dut6 (
        .clk(clk), .rst(rst), .en(en), .up(up), .ld(ld),
        .ld_lo(ld_lo2), .ld_hi(ld_hi2),
        .count_lo(count_lo2), .count_hi(count_hi2),
        .tc_lo(tc_lo2), .co(co2), .cy(cy2)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs, advance the reference model, queue the expectation.
    task automatic drive(input logic r, e, u, l, input logic [3:0] dlo, dhi,
                         output logic ecy);
        int v, old_hi;
        @(negedge clk);
        rst = r; en = e; up = u; ld = l; ld_lo = dlo; ld_hi = dhi;
        ecy = e & (u ? (m_lo == 9 && m_hi == 5) : (m_lo == 0 && m_hi == 0));
        if (r) begin
            m_lo = 0; m_hi = 0; m_tclo = 0; m_tchi = 0;
        end else if (l) begin
            m_lo = (dlo > 9) ? 9 : int'(dlo);
            m_hi = (dhi > 5) ? 5 : int'(dhi);
            m_tclo = u ? (m_lo == 9) : (m_lo == 0);
            m_tchi = u ? (m_hi == 5) : (m_hi == 0);
        end else if (e) begin
            old_hi = m_hi;
            v = m_hi * 10 + m_lo;
            v = u ? (v + 1) % 60 : (v + 59) % 60;
            m_lo = v % 10;
            m_hi = v / 10;
            m_tclo = u ? (m_lo == 9) : (m_lo == 0);
            if (m_hi != old_hi) m_tchi = u ? (m_hi == 5) : (m_hi == 0);
        end
        sb.push_back('{lo: 4'(m_lo), hi: 4'(m_hi), tclo: m_tclo, co: m_tclo & m_tchi});
    endtask

    task automatic test_reset();
        logic ecy;
        exp_t ex;
        drive(1, 0, 1, 0, 4'd0, 4'd0, ecy);
        @(posedge clk); #1;
        ex = sb.pop_front();
        checks++;
        if ({count_lo, count_hi, tc_lo, co} !== {ex.lo, ex.hi, ex.tclo, ex.co} || ex.lo != 0) begin
            errors++;
            $display("FAIL reset: got %0d/%0d tc=%0b co=%0b want 0/0 tc=0 co=0",
                     count_hi, count_lo, tc_lo, co);
        end
    endtask

    task automatic test_count_up();
        logic ecy;
        exp_t ex;
        drive(1, 0, 1, 0, 4'd0, 4'd0, ecy);
        @(posedge clk); #1; void'(sb.pop_front());
        for (int i = 0; i < 60; i++) begin
            drive(0, 1, 1, 0, 4'd0, 4'd0, ecy);
            #1;
            checks++;
            if (cy !== ecy) begin
                errors++;
                $display("FAIL up_cy step %0d: got %0b want %0b", i, cy, ecy);
            end
            @(posedge clk); #1;
            ex = sb.pop_front();
            checks++;
            if ({count_lo, count_hi, tc_lo, co} !== {ex.lo, ex.hi, ex.tclo, ex.co}) begin
                errors++;
                $display("FAIL up step %0d: got %0d/%0d tc=%0b co=%0b want %0d/%0d tc=%0b co=%0b",
                         i, count_hi, count_lo, tc_lo, co, ex.hi, ex.lo, ex.tclo, ex.co);
            end
            if (i == 58) begin
                checks++;
                if (count_hi !== 4'd5 || count_lo !== 4'd9 || co !== 1'b1) begin
                    errors++;
                    $display("FAIL up_terminal: got %0d/%0d co=%0b want 5/9 co=1",
                             count_hi, count_lo, co);
                end
            end
        end
    endtask

    task automatic test_count_down();
        logic ecy;
        exp_t ex;
        drive(1, 0, 0, 0, 4'd0, 4'd0, ecy);
        @(posedge clk); #1; void'(sb.pop_front());
        for (int i = 0; i < 60; i++) begin
            drive(0, 1, 0, 0, 4'd0, 4'd0, ecy);
            #1;
            checks++;
            if (cy !== ecy) begin
                errors++;
                $display("FAIL down_cy step %0d: got %0b want %0b", i, cy, ecy);
            end
            @(posedge clk); #1;
            ex = sb.pop_front();
            checks++;
            if ({count_lo, count_hi, tc_lo, co} !== {ex.lo, ex.hi, ex.tclo, ex.co}) begin
                errors++;
                $display("FAIL down step %0d: got %0d/%0d tc=%0b co=%0b want %0d/%0d tc=%0b co=%0b",
                         i, count_hi, count_lo, tc_lo, co, ex.hi, ex.lo, ex.tclo, ex.co);
            end
        end
        checks++;
        if (count_hi !== 4'd0 || count_lo !== 4'd0 || co !== 1'b1) begin
            errors++;
            $display("FAIL down_terminal: got %0d/%0d co=%0b want 0/0 co=1", count_hi, count_lo, co);
        end
    endtask

    task automatic test_load();
        logic ecy;
        exp_t ex;
        logic [3:0] lv [4] = '{4'd12, 4'd2, 4'd15, 4'd0};
        logic [3:0] hv [4] = '{4'd3, 4'd1, 4'd9, 4'd0};
        logic       ev [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(0, ev[i], 1, 1, lv[i], hv[i], ecy);
            @(posedge clk); #1;
            ex = sb.pop_front();
            checks++;
            if ({count_lo, count_hi, tc_lo, co} !== {ex.lo, ex.hi, ex.tclo, ex.co}) begin
                errors++;
                $display("FAIL load %0d: got %0d/%0d tc=%0b co=%0b want %0d/%0d tc=%0b co=%0b",
                         i, count_hi, count_lo, tc_lo, co, ex.hi, ex.lo, ex.tclo, ex.co);
            end
        end
    endtask

    task automatic test_hold();
        logic ecy;
        exp_t ex;
        // stimulus rows: {rst, en, up, ld, ld_lo, ld_hi}
        logic [11:0] rows [12] = '{
            {4'b0010, 4'd7, 4'd2}, {4'b0010, 4'd0, 4'd0}, {4'b0010, 4'd0, 4'd0},
            {4'b0000, 4'd0, 4'd0}, {4'b0000, 4'd0, 4'd0}, {4'b0000, 4'd0, 4'd0},
            {4'b0011, 4'd9, 4'd5}, {4'b0000, 4'd0, 4'd0}, {4'b0100, 4'd0, 4'd0},
            {4'b0011, 4'd0, 4'd0}, {4'b0100, 4'd0, 4'd0}, {4'b0110, 4'd0, 4'd0}
        };
        for (int i = 0; i < 12; i++) begin
            drive(rows[i][11], rows[i][10], rows[i][9], rows[i][8],
                  rows[i][7:4], rows[i][3:0], ecy);
            #1;
            checks++;
            if (cy !== ecy) begin
                errors++;
                $display("FAIL hold_cy row %0d: got %0b want %0b", i, cy, ecy);
            end
            @(posedge clk); #1;
            ex = sb.pop_front();
            checks++;
            if ({count_lo, count_hi, tc_lo, co} !== {ex.lo, ex.hi, ex.tclo, ex.co}) begin
                errors++;
                $display("FAIL hold row %0d: got %0d/%0d tc=%0b co=%0b want %0d/%0d tc=%0b co=%0b",
                         i, count_hi, count_lo, tc_lo, co, ex.hi, ex.lo, ex.tclo, ex.co);
            end
        end
    endtask

    task automatic test_sync_reset();
        logic ecy;
        exp_t ex;
        logic [11:0] rows [5] = '{
            {4'b0011, 4'd9, 4'd4}, {4'b1110, 4'd0, 4'd0},
            {4'b0011, 4'd9, 4'd5}, {4'b1011, 4'd9, 4'd5},
            {4'b1100, 4'd0, 4'd0}
        };
        for (int i = 0; i < 5; i++) begin
            drive(rows[i][11], rows[i][10], rows[i][9], rows[i][8],
                  rows[i][7:4], rows[i][3:0], ecy);
            @(posedge clk); #1;
            ex = sb.pop_front();
            checks++;
            if ({count_lo, count_hi, tc_lo, co} !== {ex.lo, ex.hi, ex.tclo, ex.co}) begin
                errors++;
                $display("FAIL sync_reset row %0d: got %0d/%0d tc=%0b co=%0b want %0d/%0d tc=%0b co=%0b",
                         i, count_hi, count_lo, tc_lo, co, ex.hi, ex.lo, ex.tclo, ex.co);
            end
        end
    endtask

    task automatic test_mod6();
        logic ecy;
        int   v, elo, ehi;
        drive(1, 0, 1, 0, 4'd0, 4'd0, ecy);
        @(posedge clk); #1; void'(sb.pop_front());
        for (int k = 1; k <= 12; k++) begin
            drive(0, 1, 1, 0, 4'd0, 4'd0, ecy);
            @(posedge clk); #1;
            void'(sb.pop_front());
            v   = k % 12;
            elo = v % 6;
            ehi = v / 6;
            checks++;
            if (count_lo2 !== 3'(elo) || count_hi2 !== 1'(ehi) || tc_lo2 !== (elo == 5)) begin
                errors++;
                $display("FAIL mod6 count %0d: got %0d/%0d tc=%0b want %0d/%0d tc=%0b",
                         k, count_hi2, count_lo2, tc_lo2, ehi, elo, (elo == 5));
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; ld_lo = '0; ld_hi = '0;
        m_lo = 0; m_hi = 0; m_tclo = 0; m_tchi = 0;
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_hold();
        test_sync_reset();
        test_mod6();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
